// File: rtl/led_clock_driver_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | led_clock_driver_pkg                                                 |
// | Shared FSM state type and divider clamp helper for led_clock_driver. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led_clock_driver_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // Wide carrier so the helper serves any DIV_WIDTH up to 64 bits.
  typedef logic [63:0] div_wide_t;

  function automatic div_wide_t clamp_div(input div_wide_t x);
    return (x < div_wide_t'(MIN_DIV)) ? div_wide_t'(MIN_DIV) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pwm_channel                                                      |
// | One LED output: brightness latched at PWM wrap, registered drive.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_pwm_channel #(
  parameter int PWM_BITS = 7
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_wrap,
  input  logic [PWM_BITS-1:0] i_level,
  input  logic                i_data,
  output logic                o_led
);

  logic [PWM_BITS-1:0] r_lvl_q;
  logic                r_led;

  // Level only changes on a wrap so a PWM period never mixes two duty cycles.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lvl_q <= '0;
      r_led   <= 1'b0;
    end else begin
      if (i_wrap) begin
        r_lvl_q <= i_level;
      end
      r_led <= i_data & (i_pwm_cnt < r_lvl_q);
    end
  end

  assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/led_clock_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | led_clock_driver                                                     |
// | Programmable CPU clock with run/hold/step control and PWM LEDs.      |
// | Option: LED_CLOCK_DRIVER_SYNC_EN adds 2-flop sync on RUN and STEP.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_clock_driver
  import led_clock_driver_pkg::*;
#(
  parameter int          DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = 10_000_000,
  parameter int          CHANNELS    = 8,
  parameter int          PWM_BITS    = 7
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         RUN,
  input  logic                         STEP,
  input  logic [DIV_WIDTH-1:0]         DIV,
  input  logic [CHANNELS*PWM_BITS-1:0] LEVEL,
  input  logic [CHANNELS-1:0]          DATA,
  output logic                         CPU_CLOCK,
  output logic                         TICK,
  output logic [CHANNELS-1:0]          OUTPUT
);

  localparam logic [DIV_WIDTH-1:0] c_one       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] c_reset_div = DIV_WIDTH'(clamp_div(div_wide_t'(DEFAULT_DIV)));
  localparam logic [PWM_BITS-1:0]  c_pwm_max   = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0]  c_pwm_one   = PWM_BITS'(1);

  logic w_run;
  logic w_step;

`ifdef LED_CLOCK_DRIVER_SYNC_EN
  logic [1:0] r_run_sync;
  logic [1:0] r_step_sync;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_run_sync  <= '0;
      r_step_sync <= '0;
    end else begin
      r_run_sync  <= {r_run_sync[0], RUN};
      r_step_sync <= {r_step_sync[0], STEP};
    end
  end

  assign w_run  = r_run_sync[1];
  assign w_step = r_step_sync[1];
`else
  assign w_run  = RUN;
  assign w_step = STEP;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic [DIV_WIDTH-1:0] w_div_clamp;
  logic                 r_step_d;
  logic                 r_cpu_clock;
  logic                 r_tick;
  logic                 w_step_rise;
  logic                 w_wrap;
  logic                 w_clk_nxt;

  assign w_div_clamp = DIV_WIDTH'(clamp_div(div_wide_t'(DIV)));
  assign w_step_rise = w_step & ~r_step_d;
  assign w_wrap      = (r_cnt == (r_div_q - c_one));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_one;
    w_div_nxt   = r_div_q;
    case (r_state)
      S_HOLD: begin
        w_cnt_nxt = '0;
        w_div_nxt = w_div_clamp;
        if (w_run) begin
          w_state_nxt = S_RUN;
        end else if (w_step_rise) begin
          w_state_nxt = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        // Run and single-step resolve identically at the boundary: RUN decides.
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_div_nxt   = w_div_clamp;
          w_state_nxt = w_run ? S_RUN : S_HOLD;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_div_nxt   = w_div_clamp;
        w_state_nxt = S_HOLD;
      end
    endcase
    w_clk_nxt = (w_state_nxt != S_HOLD) && (w_cnt_nxt >= (w_div_nxt >> 1));
  end

  // CPU clock is decoded from next-state values and registered, so it never glitches.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt       <= '0;
      r_div_q     <= c_reset_div;
      r_step_d    <= 1'b0;
      r_cpu_clock <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_div_q     <= w_div_nxt;
      r_step_d    <= w_step;
      r_cpu_clock <= w_clk_nxt;
      r_tick      <= w_clk_nxt & ~r_cpu_clock;
    end
  end

  assign CPU_CLOCK = r_cpu_clock;
  assign TICK      = r_tick;

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_pwm_wrap;

  assign w_pwm_wrap = (r_pwm_cnt == c_pwm_max);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= w_pwm_wrap ? '0 : (r_pwm_cnt + c_pwm_one);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_channel (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .i_pwm_cnt (r_pwm_cnt),
      .i_wrap    (w_pwm_wrap),
      .i_level   (LEVEL[g*PWM_BITS +: PWM_BITS]),
      .i_data    (DATA[g]),
      .o_led     (OUTPUT[g])
    );
  end

endmodule
`default_nettype wire

// File: doc/led_clock_driver.md
# led_clock_driver

Parametrised clock-enable and LED driver for board-level CPU demos. It generates a slow, glitch-free CPU clock with a programmable period, plus a one-cycle tick at each rising edge. It adds run, hold and single-step control, and drives CHANNELS LED outputs with per-channel PWM brightness. It sits between the board clock/buttons and the CPU core, replacing fixed divide-and-gate logic in the top level.

## Interface
- DIV_WIDTH, 32, width of period counter and DIV input
- DEFAULT_DIV, 10_000_000, period loaded at reset
- CHANNELS, 8, number of LED outputs
- PWM_BITS, 7, brightness resolution; PWM period = 2^PWM_BITS-1 cycles
- CLK  in  1  board clock; all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- RUN  in  1  1 = free-run CPU clock, 0 = hold
- STEP  in  1  rising edge while held = one CPU clock period
- DIV  in  DIV_WIDTH  requested period in CLK cycles; values <2 are treated as 2
- LEVEL  in  CHANNELS×PWM_BITS  per-channel brightness
- DATA  in  CHANNELS  per-channel logic value to display
- CPU_CLOCK  out  1  divided clock, registered
- TICK  out  1  one-cycle pulse, high in the cycle CPU_CLOCK goes 0→1
- OUTPUT  out  CHANNELS  PWM-gated LED drive, registered

## Operation
- States: S_HOLD, S_RUN, S_STEP. Reset state is S_HOLD.
- S_HOLD:
  - cnt=0; CPU_CLOCK=0; div_q reloads clamp(DIV) every cycle.
  - RUN=1 → S_RUN.
  - Else a STEP rising edge → S_STEP.
- S_RUN / S_STEP:
  - cnt counts 0..div_q-1, then wraps to 0.
  - CPU_CLOCK=1 while cnt ≥ div_q>>1.
  - Period is exactly div_q cycles: low for div_q>>1 cycles, high for the rest.
- Period boundary (cnt wraps from div_q-1):
  - div_q ← clamp(DIV). A DIV change mid-period never shortens or stretches the current period.
  - From S_RUN: RUN=0 → S_HOLD, else stay.
  - From S_STEP: RUN=1 → S_RUN, else S_HOLD.
  - No runt pulses are possible.
- STEP is edge-detected. Edges are ignored outside S_HOLD; no queuing.
- PWM:
  - pwm_cnt counts 0..2^PWM_BITS-2 and runs in all states.
  - lvl_q[i] ← LEVEL[i] when pwm_cnt wraps to 0.
  - OUTPUT[i] ← DATA[i] & (pwm_cnt < lvl_q[i]).
  - LEVEL=0 → always off; LEVEL=2^PWM_BITS-1 → always DATA.
- Arithmetic:
  - cnt is DIV_WIDTH bits unsigned; compare is against div_q>>1.
  - clamp(x) = (x<2) ? 2 : x.

## Timing
- Reset (RESET_N=0, asynchronous): cnt=0, pwm_cnt=0, lvl_q=0, div_q=clamp(DEFAULT_DIV), state=S_HOLD.
- Outputs during reset: CPU_CLOCK=0, TICK=0, OUTPUT=0. Reset mid-operation clears these immediately, with no completion of the current period.
- First rising CPU_CLOCK edge: CPU_CLOCK rises div_q>>1 cycles after S_RUN/S_STEP entry, measured from the first cycle in that state.
- TICK is high for exactly that one cycle, coincident with the CPU_CLOCK rise.
- RUN→S_RUN latency: 1 cycle (plus synchroniser delay if enabled). STEP edge→S_STEP: same.
- OUTPUT lags pwm_cnt/DATA by 1 cycle (registered).
- Simultaneous RUN=1 and STEP edge in S_HOLD: RUN wins, go to S_RUN.

## Configuration
- LED_CLOCK_DRIVER_SYNC_EN defined:
  - RUN and STEP each pass through a two-flop synchroniser, reset to 0.
  - Adds 2 cycles to RUN/STEP latency; safe for raw button inputs.
- Undefined: RUN and STEP are used directly and must be synchronous to CLK.

## Structure
- Package led_clock_driver_pkg:
  - state enum (S_HOLD, S_RUN, S_STEP)
  - MIN_DIV=2
  - clamp_div function
- Sub-module led_pwm_channel:
  - inputs: pwm_cnt, wrap strobe, LEVEL, DATA
  - holds lvl_q and the registered OUTPUT bit
  - generate-instantiated CHANNELS times
- Divider, FSM and pwm_cnt live in led_clock_driver.

## Test plan
- DIV=10, RUN=1 after reset → CPU_CLOCK 5 cycles low / 5 high, repeating; TICK once every 10 cycles, aligned to the rise.
- DIV=0 and DIV=1 → behaves as DIV=2: CPU_CLOCK toggles every cycle, TICK every 2 cycles.
- DIV changed 10→4 at cnt=3 → current period completes at 10 cycles; following periods are 4 cycles (2 low/2 high).
- RUN=0, DIV=6, single STEP pulse → one period (3 low/3 high), exactly one TICK, then CPU_CLOCK held 0. A second STEP during that period is ignored.
- RUN dropped mid-high-phase → high phase finishes, then CPU_CLOCK stays 0; no shortened pulse.
- PWM_BITS=3, DATA=1:
  - LEVEL=3 → OUTPUT high 3 of every 7 cycles.
  - LEVEL=7 → constant 1.
  - LEVEL=0 → constant 0.
  - DATA=0 → constant 0.
  - LEVEL changed mid-period takes effect at the next wrap.
- RESET_N asserted during the S_RUN high phase → CPU_CLOCK, TICK and OUTPUT go 0 asynchronously; after release, state is S_HOLD until RUN=1.
